// File: rtl/eth_rx_pkg.sv
// Shared types, CRC constants and helpers for the Ethernet receive frame writer.
package eth_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      DROP   = 2'd2,
      COMMIT = 2'd3
   } rxState_e;

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [31:0] satInc(input logic [31:0] v, input int unsigned w);
      logic [31:0] maxV;
      maxV = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= maxV) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update for one byte (LSB first).
module eth_crc32_byte
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   always_comb begin
      crc_o = crc_i ^ {24'd0, data_i};
      for (int i = 0; i < 8; i++) begin
         crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC_POLY) : (crc_o >> 1);
      end
   end

endmodule

// File: rtl/eth_rx_writer.sv
// Receive frame writer: streams MAC bytes into the RX buffer and publishes a frame ticket.
// Optional FCS checking is enabled with the ETH_RX_CRC_CHECK_EN macro.
module eth_rx_writer
   import eth_rx_pkg::*;
#(
   parameter int BUF_BYTES = 2048,
   parameter int W_LEN     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   input  logic             s_first,
   input  logic             s_last,
   input  logic             s_err,
   input  logic [W_LEN-1:0] rx_read,
   output logic             buf_we,
   output logic [31:0]      buf_addr,
   output logic [7:0]       buf_wdata,
   output logic [W_LEN-1:0] rx_len,
   output logic [W_LEN-1:0] rx_wrote,
   output logic             rx_busy,
   output logic [W_LEN-1:0] n_discarded,
   output logic [W_LEN-1:0] n_crc_err
);

   localparam int CNTW = $clog2(BUF_BYTES + 1);

   rxState_e         state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [W_LEN-1:0] len_q, len_d;
   logic [W_LEN-1:0] wrote_q, wrote_d;
   logic [W_LEN-1:0] disc_q, disc_d;
   logic             doStart;

`ifdef ETH_RX_CRC_CHECK_EN
   logic [31:0]      crc_q, crc_d, crcSeed, crcNext;
   logic [W_LEN-1:0] crcErr_q, crcErr_d;

   // A byte continues the running CRC only inside an open frame; any first byte reseeds.
   assign crcSeed = (state_q == RECV && !s_first) ? crc_q : CRC_INIT;

   eth_crc32_byte u_crc (
      .crc_i  (crcSeed),
      .data_i (s_data),
      .crc_o  (crcNext)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      wrote_d = wrote_q;
      disc_d  = disc_q;
      doStart = 1'b0;
`ifdef ETH_RX_CRC_CHECK_EN
      crc_d    = crc_q;
      crcErr_d = crcErr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (s_valid && s_first) doStart = 1'b1;
         end
         RECV: begin
            if (s_valid) begin
               if (s_first) begin
                  disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
                  doStart = 1'b1;
               end else if (cnt_q == CNTW'(BUF_BYTES)) begin
                  if (s_last) begin
                     disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
                     state_d = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  we_d    = 1'b1;
                  addr_d  = 32'(cnt_q);
                  wdata_d = s_data;
                  cnt_d   = cnt_q + CNTW'(1);
`ifdef ETH_RX_CRC_CHECK_EN
                  crc_d   = crcNext;
`endif
                  if (s_last) begin
                     if (s_err) begin
                        disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
                        state_d = IDLE;
                     end else begin
                        state_d = COMMIT;
                     end
                  end
               end
            end
         end
         DROP: begin
            if (s_valid) begin
               if (s_first) begin
                  doStart = 1'b1;
               end else if (s_last) begin
                  disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
                  state_d = IDLE;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
`ifdef ETH_RX_CRC_CHECK_EN
            if (crc_q == CRC_RESIDUE && cnt_q > CNTW'(4)) begin
               len_d   = W_LEN'(cnt_q - CNTW'(4));
               wrote_d = wrote_q + W_LEN'(1);
            end else begin
               crcErr_d = W_LEN'(satInc(32'(crcErr_q), unsigned'(W_LEN)));
            end
`else
            len_d   = W_LEN'(cnt_q);
            wrote_d = wrote_q + W_LEN'(1);
`endif
            if (s_valid && s_first) doStart = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Occupancy uses wrote_d so a first byte during COMMIT sees the freshly published ticket.
      if (doStart) begin
         if (wrote_d != rx_read) begin
            if (s_last) begin
               disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end else begin
            we_d    = 1'b1;
            addr_d  = 32'd0;
            wdata_d = s_data;
            cnt_d   = CNTW'(1);
`ifdef ETH_RX_CRC_CHECK_EN
            crc_d   = crcNext;
`endif
            if (s_last) begin
               if (s_err) begin
                  disc_d  = W_LEN'(satInc(32'(disc_d), unsigned'(W_LEN)));
                  state_d = IDLE;
               end else begin
                  state_d = COMMIT;
               end
            end else begin
               state_d = RECV;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         len_q   <= '0;
         wrote_q <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         wrote_q <= wrote_d;
         disc_q  <= disc_d;
      end
   end

`ifdef ETH_RX_CRC_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q    <= CRC_INIT;
         crcErr_q <= '0;
      end else begin
         crc_q    <= crc_d;
         crcErr_q <= crcErr_d;
      end
   end
   assign n_crc_err = crcErr_q;
`else
   assign n_crc_err = '0;
`endif

   assign buf_we      = we_q;
   assign buf_addr    = addr_q;
   assign buf_wdata   = wdata_q;
   assign rx_len      = len_q;
   assign rx_wrote    = wrote_q;
   assign rx_busy     = (state_q == RECV) || (state_q == COMMIT);
   assign n_discarded = disc_q;

endmodule

// File: tb/tb_eth_rx_writer.sv
// Directed scoreboard bench for eth_rx_writer: expected buffer writes are queued as bytes are driven.
module tb_eth_rx_writer;

   localparam int BUF_BYTES = 2048;
   localparam int W_LEN     = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             s_valid = 1'b0;
   logic [7:0]       s_data = 8'd0;
   logic             s_first = 1'b0;
   logic             s_last = 1'b0;
   logic             s_err = 1'b0;
   logic [W_LEN-1:0] rx_read = '0;
   logic             buf_we;
   logic [31:0]      buf_addr;
   logic [7:0]       buf_wdata;
   logic [W_LEN-1:0] rx_len;
   logic [W_LEN-1:0] rx_wrote;
   logic             rx_busy;
   logic [W_LEN-1:0] n_discarded;
   logic [W_LEN-1:0] n_crc_err;

   int          errors = 0;
   int          checks = 0;
   int          nWrites = 0;
   int          writesBefore;
   int          flipIdx = -1;
   logic [39:0] expQ[$];
   logic [39:0] expWr;
   logic [7:0]  frameBuf [0:2199];

   eth_rx_writer #(.BUF_BYTES(BUF_BYTES), .W_LEN(W_LEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_first     (s_first),
      .s_last      (s_last),
      .s_err       (s_err),
      .rx_read     (rx_read),
      .buf_we      (buf_we),
      .buf_addr    (buf_addr),
      .buf_wdata   (buf_wdata),
      .rx_len      (rx_len),
      .rx_wrote    (rx_wrote),
      .rx_busy     (rx_busy),
      .n_discarded (n_discarded),
      .n_crc_err   (n_crc_err)
   );

   always #5 clk = ~clk;

   // Every observed buffer write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (buf_we) begin
         nWrites++;
         checks++;
         assert (expQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_write observed addr=%0d data=%h expected no write", buf_addr, buf_wdata);
         end
         if (expQ.size() != 0) begin
            expWr = expQ.pop_front();
            assert ({buf_addr, buf_wdata} === expWr) else begin
               errors++;
               $error("[TB] FAIL write observed addr=%0d data=%h expected addr=%0d data=%h",
                      buf_addr, buf_wdata, expWr[39:8], expWr[7:0]);
            end
         end
      end
   end

`ifdef ETH_RX_CRC_CHECK_EN
   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 8; b++) begin
         if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction
`endif

   function automatic int expLen(input int n);
`ifdef ETH_RX_CRC_CHECK_EN
      return n - 4;
`else
      return n;
`endif
   endfunction

   // Payload bytes are seed+i; with FCS checking the last four bytes carry a valid FCS.
   task automatic buildFrame(input int len, input logic [7:0] seed);
      for (int i = 0; i < len; i++) frameBuf[i] = seed + 8'(i);
`ifdef ETH_RX_CRC_CHECK_EN
      if (len > 4) begin
         logic [31:0] c;
         c = 32'hFFFFFFFF;
         for (int i = 0; i < len - 4; i++) c = crcByte(c, frameBuf[i]);
         c = ~c;
         for (int k = 0; k < 4; k++) frameBuf[len-4+k] = c[8*k +: 8];
      end
`endif
      if (flipIdx >= 0) frameBuf[flipIdx] = frameBuf[flipIdx] ^ 8'h01;
   endtask

   task automatic applyStimulus(input int len, input logic [7:0] seed, input bit withFirst,
                                input bit withLast, input bit errLast, input int expWrites);
      buildFrame(len, seed);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         s_valid = 1'b1;
         s_data  = frameBuf[i];
         s_first = withFirst && (i == 0);
         s_last  = withLast && (i == len - 1);
         s_err   = errLast && (i == len - 1);
         if (i < expWrites) expQ.push_back({32'(i), frameBuf[i]});
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
      s_err   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic checkAllZero(input string phase);
      checkOutput({phase, "_buf_we"}, 32'(buf_we), 32'd0);
      checkOutput({phase, "_buf_addr"}, buf_addr, 32'd0);
      checkOutput({phase, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
      checkOutput({phase, "_rx_len"}, 32'(rx_len), 32'd0);
      checkOutput({phase, "_rx_wrote"}, 32'(rx_wrote), 32'd0);
      checkOutput({phase, "_rx_busy"}, 32'(rx_busy), 32'd0);
      checkOutput({phase, "_n_discarded"}, 32'(n_discarded), 32'd0);
      checkOutput({phase, "_n_crc_err"}, 32'(n_crc_err), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 64-byte frame: ticket moves exactly two cycles after the last byte.
      applyStimulus(64, 8'h00, 1, 1, 0, 64);
      @(negedge clk);
      checkOutput("a_wrote_in_commit", 32'(rx_wrote), 32'd0);
      checkOutput("a_busy_in_commit", 32'(rx_busy), 32'd1);
      @(negedge clk);
      checkOutput("a_wrote", 32'(rx_wrote), 32'd1);
      checkOutput("a_len", 32'(rx_len), 32'(expLen(64)));
      checkOutput("a_busy_after", 32'(rx_busy), 32'd0);
      checkOutput("a_pending", 32'(expQ.size()), 32'd0);

      // Buffer occupied: whole frame dropped.
      applyStimulus(30, 8'h40, 1, 1, 0, 0);
      settle();
      checkOutput("b_discarded", 32'(n_discarded), 32'd1);
      checkOutput("b_wrote", 32'(rx_wrote), 32'd1);

      rx_read = 16'd1;
      applyStimulus(30, 8'h60, 1, 1, 0, 30);
      settle();
      checkOutput("c_wrote", 32'(rx_wrote), 32'd2);
      checkOutput("c_len", 32'(rx_len), 32'(expLen(30)));
      checkOutput("c_pending", 32'(expQ.size()), 32'd0);

      // Oversize frame: buffer fills, remainder dropped.
      rx_read = 16'd2;
      writesBefore = nWrites;
      applyStimulus(BUF_BYTES + 1, 8'h11, 1, 1, 0, BUF_BYTES);
      settle();
      checkOutput("big_writes", 32'(nWrites - writesBefore), 32'(BUF_BYTES));
      checkOutput("big_discarded", 32'(n_discarded), 32'd2);
      checkOutput("big_wrote", 32'(rx_wrote), 32'd2);
      applyStimulus(16, 8'hA0, 1, 1, 0, 16);
      settle();
      checkOutput("after_big_wrote", 32'(rx_wrote), 32'd3);
      checkOutput("after_big_len", 32'(rx_len), 32'(expLen(16)));

      // MAC error on last byte.
      rx_read = 16'd3;
      applyStimulus(20, 8'hC0, 1, 1, 1, 20);
      settle();
      checkOutput("err_discarded", 32'(n_discarded), 32'd3);
      checkOutput("err_wrote", 32'(rx_wrote), 32'd3);

      // New first byte at byte 10 aborts the open frame.
      applyStimulus(10, 8'h80, 1, 0, 0, 10);
      applyStimulus(12, 8'h90, 1, 1, 0, 12);
      settle();
      checkOutput("abort_discarded", 32'(n_discarded), 32'd4);
      checkOutput("abort_wrote", 32'(rx_wrote), 32'd4);
      checkOutput("abort_len", 32'(rx_len), 32'(expLen(12)));
      checkOutput("abort_pending", 32'(expQ.size()), 32'd0);

      // Reset mid-frame, then trailing bytes without a first byte.
      rx_read = 16'd4;
      applyStimulus(8, 8'h20, 1, 0, 0, 8);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      @(posedge clk); #1;
      rst_n   = 1'b1;
      rx_read = 16'd0;
      applyStimulus(6, 8'h28, 0, 1, 0, 0);
      settle();
      checkOutput("trail_discarded", 32'(n_discarded), 32'd0);
      checkOutput("trail_wrote", 32'(rx_wrote), 32'd0);
      checkOutput("trail_addr", buf_addr, 32'd0);
      applyStimulus(20, 8'h33, 1, 1, 0, 20);
      settle();
      checkOutput("post_reset_wrote", 32'(rx_wrote), 32'd1);
      checkOutput("post_reset_len", 32'(rx_len), 32'(expLen(20)));

`ifdef ETH_RX_CRC_CHECK_EN
      rx_read = 16'd1;
      applyStimulus(40, 8'h55, 1, 1, 0, 40);
      settle();
      checkOutput("crc_good_wrote", 32'(rx_wrote), 32'd2);
      rx_read = 16'd2;
      flipIdx = 3;
      applyStimulus(40, 8'h55, 1, 1, 0, 40);
      flipIdx = -1;
      settle();
      checkOutput("crc_bad_count", 32'(n_crc_err), 32'd1);
      checkOutput("crc_bad_wrote", 32'(rx_wrote), 32'd2);
`endif

      checkOutput("final_pending", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_writer.md
# eth_rx_writer

Receive-side frame writer for the Ethernet peripheral. Accepts the byte stream from the MAC receive path, writes each accepted frame byte-by-byte into port A of the RX frame buffer, and publishes its length and a frame-written ticket counter. The APB-facing Ethernet controller compares these against its read ticket and reads the frame through port B. One frame is buffered at a time; frames arriving while the buffer is occupied are dropped and counted.

## Interface
- BUF_BYTES, 2048: RX buffer capacity in bytes; must be at least `ETHERNET_MTU`.
- W_LEN, 16: width of the length, ticket and counter outputs.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input byte valid; no backpressure.
- s_data  in  8  input byte.
- s_first  in  1  first byte of frame; qualified by s_valid.
- s_last  in  1  last byte of frame; qualified by s_valid.
- s_err  in  1  MAC error; sampled with s_last.
- rx_read  in  W_LEN  host read ticket.
- buf_we  out  1  buffer write strobe; registered.
- buf_addr  out  32  buffer byte address; registered.
- buf_wdata  out  8  buffer write byte; registered.
- rx_len  out  W_LEN  length of the last committed frame.
- rx_wrote  out  W_LEN  committed-frame ticket; wraps modulo 2^W_LEN.
- rx_busy  out  1  high in RECV or COMMIT.
- n_discarded  out  W_LEN  dropped-frame count; saturates.
- n_crc_err  out  W_LEN  FCS failure count; saturates; 0 when CRC is not compiled in.

## Operation
- States: IDLE, RECV, DROP, COMMIT. Reset state is IDLE.
- Buffer occupied means rx_wrote != rx_read.
- IDLE:
  - Bytes without s_first are ignored and not counted.
  - s_valid&&s_first with buffer occupied: go to DROP. If s_last is also set, increment n_discarded and stay in IDLE.
  - Otherwise: write the byte at address 0, set cnt=1, go to RECV. If s_last is also set, go to COMMIT instead (s_err discards).
- RECV, on each s_valid byte:
  - s_first: abort the current frame, increment n_discarded, restart as in IDLE.
  - cnt==BUF_BYTES (no room): go to DROP. If s_last is also set, count the discard and go to IDLE.
  - Otherwise: write the byte at cnt, then cnt++.
  - s_last with s_err: increment n_discarded, go to IDLE.
  - s_last without s_err: go to COMMIT.
- COMMIT (one cycle): rx_len<=cnt, rx_wrote<=rx_wrote+1, go to IDLE. A byte arriving during COMMIT is handled as in IDLE against the updated ticket, so the buffer is seen as occupied.
- DROP: discard bytes until s_valid&&s_last, then increment n_discarded and go to IDLE. An s_first byte in DROP is treated as in IDLE.
- Reset mid-frame: state and all outputs return to reset values. Trailing bytes are ignored until the next s_first.

## Timing
- Reset values: buf_we=0, buf_addr=0, buf_wdata=0, rx_len=0, rx_wrote=0, rx_busy=0, n_discarded=0, n_crc_err=0.
- A byte accepted in cycle N appears on buf_we/buf_addr/buf_wdata in cycle N+1.
- Last byte in cycle N: COMMIT in N+1; rx_wrote/rx_len visible in N+2. The buffer write therefore lands before the ticket changes.
- Throughput: one byte per clk. Any gap length is allowed between bytes.
- A change in rx_read takes effect on the next first-byte decision; no lag.

## Configuration
- ETH_RX_CRC_CHECK_EN defined:
  - Runs reflected CRC-32 (polynomial 0xEDB88320, init 0xFFFFFFFF) over all frame bytes including the FCS.
  - In COMMIT, the register must equal 0xDEBB20E3 and cnt must be >4. Otherwise increment n_crc_err and leave rx_wrote/rx_len unchanged.
  - On success, rx_len=cnt-4 (FCS stripped).
- Undefined: no CRC logic; rx_len=cnt; n_crc_err is tied to 0.

## Structure
- Shared package eth_rx_pkg holds:
  - state encoding;
  - CRC_POLY, CRC_INIT, CRC_RESIDUE;
  - saturating-increment helper.
- Buffer size comes from `ETHERNET_MTU in define.vh.
- One sub-module: eth_crc32_byte, combinational next-CRC from (crc, byte); instantiated only under ETH_RX_CRC_CHECK_EN.

## Test plan
- 64-byte frame 0x00..0x3F, rx_read=0 -> 64 writes to addresses 0..63 with matching data; rx_len=64 (60 with CRC and valid FCS); rx_wrote=1 two cycles after the last byte.
- Second frame with rx_read=0, rx_wrote=1 -> no buf_we, n_discarded=1, rx_wrote=1. Then set rx_read=1 and send a third frame -> accepted, rx_wrote=2.
- 2049-byte frame, BUF_BYTES=2048 -> exactly 2048 writes, n_discarded=1, rx_wrote unchanged, next frame accepted.
- 20-byte frame with s_err on the last byte -> n_discarded=1, rx_wrote unchanged.
- ETH_RX_CRC_CHECK_EN: frame with correct FCS -> rx_wrote=1. Same frame with one data bit flipped -> n_crc_err=1, rx_wrote=1.
- s_first at byte 10 of an open frame -> n_discarded=1 and the new frame is written from address 0. Reset pulse mid-frame -> all outputs 0, trailing bytes produce no writes.
